key_press_classifier: RTL



---
 rtl/key_pkg.sv | 20 ++
 rtl/kpc_hold_counter.sv | 36 +++
 rtl/key_press_classifier.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// key_pkg: definitions shared by the key press classifier and its
// neighbours (debouncer, UI FSM).
//   - FSM state encoding used by key_press_classifier
//   - default long-press and auto-repeat periods, in clk cycles
package key_pkg;

    localparam logic [1:0] KPC_IDLE    = 2'd0;
    localparam logic [1:0] KPC_PRESSED = 2'd1;
    localparam logic [1:0] KPC_LONG    = 2'd2;

    localparam int KPC_LONG_CYCLES_DEF   = 8;
    localparam int KPC_REPEAT_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = KPC_IDLE,
        ST_PRESSED = KPC_PRESSED,
        ST_LONG    = KPC_LONG
    } kpc_state_t;

endpackage

// File: rtl/kpc_hold_counter.sv
// kpc_hold_counter: saturating up-counter with clear and terminal match.
//   clk, reset : clock, asynchronous active-high reset (count -> 0)
//   clr        : next count starts from 0 (combined with inc, this loads 1)
//   inc        : add one, holding at all-ones instead of wrapping
//   match      : count currently equals MATCH
module kpc_hold_counter #(
    parameter int W     = 8,
    parameter int MATCH = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic match
);

    logic [W-1:0] cnt;
    logic [W-1:0] base;
    logic         at_max;

    always_comb begin
        base   = clr ? '0 : cnt;
        at_max = &base;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= base + W'(inc & ~at_max);
        end
    end

    assign match = (cnt == W'(MATCH));

endmodule

// File: rtl/key_press_classifier.sv
// key_press_classifier: turns the debounced key level into one-cycle
// short/long/repeat events and keeps a wrapping press count.
//   clk          : system clock, rising edge
//   reset        : asynchronous, active-high
//   key_in       : debounced key level, 1 = pressed
//   short_pulse  : released before LONG_CYCLES high samples
//   long_pulse   : LONG_CYCLES-th high sample reached
//   repeat_pulse : auto-repeat tick while long-held (0 unless KPC_REPEAT_EN)
//   press_count  : presses (and repeats) seen, modulo 2**COUNT_W
//   busy         : FSM is not IDLE
// Optional build macro: KPC_REPEAT_EN enables the auto-repeat logic.
module key_press_classifier
    import key_pkg::*;
#(
    parameter int LONG_CYCLES   = KPC_LONG_CYCLES_DEF,
    parameter int HOLD_W        = 8,
    parameter int COUNT_W       = 4,
    parameter int REPEAT_CYCLES = KPC_REPEAT_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_in,
    output logic               short_pulse,
    output logic               long_pulse,
    output logic               repeat_pulse,
    output logic [COUNT_W-1:0] press_count,
    output logic               busy
);

    if (LONG_CYCLES < 2 || REPEAT_CYCLES < 1 || (2 ** HOLD_W) <= LONG_CYCLES) begin : g_bad_param
        $error("key_press_classifier: illegal parameter combination");
    end

    kpc_state_t state;
    logic       hold_clr;
    logic       hold_inc;
    logic       hold_match;
    logic       rep_fire;

    // Hold counter: loads 1 on the first high sample in IDLE, counts while
    // held (saturating in LONG_HELD), clears on any low sample.
    always_comb begin
        hold_clr = 1'b1;
        hold_inc = 1'b0;
        case (state)
            ST_IDLE: begin
                hold_inc = key_in;
            end
            ST_PRESSED, ST_LONG: begin
                if (key_in) begin
                    hold_clr = 1'b0;
                    hold_inc = 1'b1;
                end
            end
            default: begin
                hold_clr = 1'b1;
                hold_inc = 1'b0;
            end
        endcase
    end

    kpc_hold_counter #(
        .W     (HOLD_W),
        .MATCH (LONG_CYCLES - 1)
    ) u_hold_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (hold_clr),
        .inc   (hold_inc),
        .match (hold_match)
    );

`ifdef KPC_REPEAT_EN
    localparam int REP_W = (REPEAT_CYCLES < 2) ? 2 : $clog2(REPEAT_CYCLES) + 1;

    logic rep_active;
    logic rep_match;

    // rep_cnt is zero on entry to LONG_HELD (it is held clear everywhere
    // else) and restarts from zero after every repeat tick.
    assign rep_active = (state == ST_LONG) && key_in;
    assign rep_fire   = rep_active && rep_match;

    kpc_hold_counter #(
        .W     (REP_W),
        .MATCH (REPEAT_CYCLES - 1)
    ) u_rep_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (~rep_active | rep_match),
        .inc   (rep_active & ~rep_match),
        .match (rep_match)
    );
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            short_pulse  <= 1'b0;
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
            press_count  <= '0;
            busy         <= 1'b0;
        end else begin
            short_pulse  <= 1'b0;
            long_pulse   <= 1'b0;
            repeat_pulse <= rep_fire;
            // rep_fire only occurs in LONG_HELD, so it never collides with
            // the IDLE press increment below.
            if (rep_fire) begin
                press_count <= press_count + COUNT_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (key_in) begin
                        state       <= ST_PRESSED;
                        busy        <= 1'b1;
                        press_count <= press_count + COUNT_W'(1);
                    end
                end
                ST_PRESSED: begin
                    if (!key_in) begin
                        state       <= ST_IDLE;
                        busy        <= 1'b0;
                        short_pulse <= 1'b1;
                    end else if (hold_match) begin
                        state      <= ST_LONG;
                        long_pulse <= 1'b1;
                    end
                end
                ST_LONG: begin
                    if (!key_in) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
